// File: rtl/id_stage_pkg.sv
// Shared widths, opcode map, instruction field positions and the opcode decoder
// used by the decode stage and its register file.
package id_stage_pkg;

  localparam int DSIZE = 16;
  localparam int NREG  = 16;

  // Instruction fields: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt / imm4.
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 0;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_COM  = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;

  typedef struct packed {
    logic legal;
    logic uses_rt;
    logic use_imm;
    logic we;
    logic memread;
    logic memwrite;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL: begin
        c.legal   = 1'b1;
        c.uses_rt = 1'b1;
        c.we      = 1'b1;
      end
      OP_ADDI: begin
        c.legal   = 1'b1;
        c.use_imm = 1'b1;
        c.we      = 1'b1;
      end
      OP_LW: begin
        c.legal   = 1'b1;
        c.use_imm = 1'b1;
        c.we      = 1'b1;
        c.memread = 1'b1;
      end
      OP_SW: begin
        c.legal    = 1'b1;
        c.uses_rt  = 1'b1;
        c.use_imm  = 1'b1;
        c.memwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Register file: two combinational read ports with write-through bypass, one
// synchronous write port, r0 hardwired to zero.
module id_stage_regfile
  import id_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ra1,
  input  logic [3:0]       ra2,
  output logic [DSIZE-1:0] rd1,
  output logic [DSIZE-1:0] rd2,
  input  logic             we,
  input  logic [3:0]       wa,
  input  logic [DSIZE-1:0] wd
);

  logic [DSIZE-1:0] mem_q [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst || gi == 0) begin
          mem_q[gi] <= '0;
        end else if (we && wa == 4'(gi)) begin
          mem_q[gi] <= wd;
        end
      end
    end
  endgenerate

  // r0 check comes first so a write to r0 can never bypass onto a read of r0.
  always_comb begin
    rd1 = mem_q[ra1];
    if (ra1 == 4'd0)               rd1 = '0;
    else if (we && wa == ra1)      rd1 = wd;
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if (ra2 == 4'd0)               rd2 = '0;
    else if (we && wa == ra2)      rd2 = wd;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode: register read, load-use hazard detection and the ID/EX
// pipeline register feeding the execute-stage ALU.
module id_stage
  import id_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      id_instr,
  input  logic             id_valid,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [3:0]       wb_rd,
  input  logic [DSIZE-1:0] wb_data,
  output logic             stall,
  output logic             ex_valid,
  output logic [3:0]       ex_op,
  output logic [DSIZE-1:0] ex_a,
  output logic [DSIZE-1:0] ex_b,
  output logic [DSIZE-1:0] ex_sd,
  output logic [3:0]       ex_rd,
  output logic             ex_we,
  output logic             ex_memread,
  output logic             ex_memwrite
);

  logic [3:0]       op, rd, rs, rt;
  logic [DSIZE-1:0] rs_val, rt_val, imm_ext;
  ctrl_t            ctrl;
  logic             issue;

  logic             ex_valid_q, ex_valid_d;
  logic [3:0]       ex_op_q, ex_op_d;
  logic [DSIZE-1:0] ex_a_q, ex_a_d;
  logic [DSIZE-1:0] ex_b_q, ex_b_d;
  logic [DSIZE-1:0] ex_sd_q, ex_sd_d;
  logic [3:0]       ex_rd_q, ex_rd_d;
  logic             ex_we_q, ex_we_d;
  logic             ex_memread_q, ex_memread_d;
  logic             ex_memwrite_q, ex_memwrite_d;

  assign op = id_instr[OP_LSB +: 4];
  assign rd = id_instr[RD_LSB +: 4];
  assign rs = id_instr[RS_LSB +: 4];
  assign rt = id_instr[RT_LSB +: 4];
  // imm4 and rt share the low nibble; SW uses it as both offset and data source.
  assign imm_ext = {{(DSIZE-4){rt[3]}}, rt};
  assign ctrl    = decode_op(op);

  id_stage_regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_val),
    .rd2 (rt_val),
    .we  (wb_we),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  // Flush wins over stall so a taken branch redirects the PC immediately.
  assign stall = !rst && id_valid && !flush && ex_valid_q && ex_memread_q &&
                 (ex_rd_q != 4'd0) &&
                 ((ex_rd_q == rs) || (ctrl.uses_rt && ex_rd_q == rt));

  assign issue = id_valid && !flush && !stall && ctrl.legal;

  always_comb begin
    ex_valid_d    = 1'b0;
    ex_op_d       = '0;
    ex_a_d        = '0;
    ex_b_d        = '0;
    ex_sd_d       = '0;
    ex_rd_d       = '0;
    ex_we_d       = 1'b0;
    ex_memread_d  = 1'b0;
    ex_memwrite_d = 1'b0;
    if (issue) begin
      ex_valid_d    = 1'b1;
      ex_op_d       = op;
      ex_a_d        = rs_val;
      ex_b_d        = ctrl.use_imm ? imm_ext : rt_val;
      ex_sd_d       = ctrl.memwrite ? rt_val : '0;
      ex_rd_d       = rd;
      ex_we_d       = ctrl.we;
      ex_memread_d  = ctrl.memread;
      ex_memwrite_d = ctrl.memwrite;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_op_q       <= '0;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      ex_sd_q       <= '0;
      ex_rd_q       <= '0;
      ex_we_q       <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_op_q       <= ex_op_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
      ex_sd_q       <= ex_sd_d;
      ex_rd_q       <= ex_rd_d;
      ex_we_q       <= ex_we_d;
      ex_memread_q  <= ex_memread_d;
      ex_memwrite_q <= ex_memwrite_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_op       = ex_op_q;
  assign ex_a        = ex_a_q;
  assign ex_b        = ex_b_q;
  assign ex_sd       = ex_sd_q;
  assign ex_rd       = ex_rd_q;
  assign ex_we       = ex_we_q;
  assign ex_memread  = ex_memread_q;
  assign ex_memwrite = ex_memwrite_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-computed expectations checked with
// immediate assertions after each step.
module tb_id_stage;
  import id_stage_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      id_instr;
  logic             id_valid;
  logic             flush;
  logic             wb_we;
  logic [3:0]       wb_rd;
  logic [DSIZE-1:0] wb_data;
  logic             stall;
  logic             ex_valid;
  logic [3:0]       ex_op;
  logic [DSIZE-1:0] ex_a, ex_b, ex_sd;
  logic [3:0]       ex_rd;
  logic             ex_we, ex_memread, ex_memwrite;

  int checks = 0;
  int failures = 0;

  id_stage dut (
    .clk         (clk),
    .rst         (rst),
    .id_instr    (id_instr),
    .id_valid    (id_valid),
    .flush       (flush),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_op       (ex_op),
    .ex_a        (ex_a),
    .ex_b        (ex_b),
    .ex_sd       (ex_sd),
    .ex_rd       (ex_rd),
    .ex_we       (ex_we),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt);
    return {op, rd, rs, rt};
  endfunction

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, {15'd0, ex_valid}, 16'd0);
    check({tag, "_ctl"}, {13'd0, ex_we, ex_memread, ex_memwrite}, 16'd0);
  endtask

  initial begin
    // Reset with random inputs for two cycles.
    rst      = 1'b1;
    id_instr = 16'($urandom);
    id_valid = 1'b1;
    flush    = 1'b0;
    wb_we    = 1'b1;
    wb_rd    = 4'($urandom);
    wb_data  = 16'($urandom);
    #1;
    check("rst_stall_pre", {15'd0, stall}, 16'd0);
    step();
    id_instr = 16'($urandom);
    wb_rd    = 4'($urandom);
    wb_data  = 16'($urandom);
    step();
    check("rst_stall", {15'd0, stall}, 16'd0);
    check("rst_ctl", {11'd0, ex_valid, ex_we, ex_memread, ex_memwrite, 1'b0}, 16'd0);
    check("rst_op_rd", {8'd0, ex_op, ex_rd}, 16'd0);
    check("rst_a", ex_a, 16'd0);
    check("rst_b", ex_b, 16'd0);
    check("rst_sd", ex_sd, 16'd0);

    rst   = 1'b0;
    wb_we = 1'b0;
    flush = 1'b0;
    // R[1..15] read back 0 after reset.
    for (int i = 1; i < 16; i++) begin
      id_instr = ins(OP_ADD, 4'd0, 4'(i), 4'(i));
      id_valid = 1'b1;
      step();
      check($sformatf("rst_reg%0d", i), ex_a | ex_b, 16'd0);
      $display("reg r%0d read a=%h b=%h", i, ex_a, ex_b);
    end

    // Writeback R1=5, R2=7, then ADD r3,r1,r2.
    id_valid = 1'b0;
    wb_we = 1'b1; wb_rd = 4'd1; wb_data = 16'd5;
    step();
    wb_rd = 4'd2; wb_data = 16'd7;
    step();
    wb_we = 1'b0;
    id_instr = ins(OP_ADD, 4'd3, 4'd1, 4'd2); id_valid = 1'b1;
    step();
    check("add_op", {12'd0, ex_op}, {12'd0, OP_ADD});
    check("add_a", ex_a, 16'd5);
    check("add_b", ex_b, 16'd7);
    check("add_rd", {12'd0, ex_rd}, 16'd3);
    check("add_ctl", {12'd0, ex_valid, ex_we, ex_memread, ex_memwrite}, 16'b1100);
    $display("ADD r3,r1,r2 a=%h b=%h", ex_a, ex_b);

    // ADDI r4,r1,-2
    id_instr = ins(OP_ADDI, 4'd4, 4'd1, 4'hE);
    step();
    check("addi_op", {12'd0, ex_op}, {12'd0, OP_ADDI});
    check("addi_a", ex_a, 16'd5);
    check("addi_b", ex_b, 16'hFFFE);
    check("addi_rd", {12'd0, ex_rd}, 16'd4);
    $display("ADDI r4,r1,-2 b=%h", ex_b);

    // Load-use on rs: LW r5,0(r1); ADD r6,r5,r2.
    id_instr = ins(OP_LW, 4'd5, 4'd1, 4'd0);
    step();
    check("lw_ctl", {12'd0, ex_valid, ex_we, ex_memread, ex_memwrite}, 16'b1110);
    check("lw_rd", {12'd0, ex_rd}, 16'd5);
    id_instr = ins(OP_ADD, 4'd6, 4'd5, 4'd2);
    #1;
    check("lu_rs_stall", {15'd0, stall}, 16'd1);
    step();
    check_bubble("lu_rs_bubble");
    // Held ADD decodes again while writeback delivers R5.
    wb_we = 1'b1; wb_rd = 4'd5; wb_data = 16'h00AA;
    #1;
    check("lu_rs_release", {15'd0, stall}, 16'd0);
    step();
    wb_we = 1'b0;
    check("lu_rs_valid", {15'd0, ex_valid}, 16'd1);
    check("lu_rs_a", ex_a, 16'h00AA);
    check("lu_rs_b", ex_b, 16'd7);
    check("lu_rs_rd", {12'd0, ex_rd}, 16'd6);
    $display("load-use rs: ADD a=%h b=%h", ex_a, ex_b);

    // Control: LW r5 then ADDI r6,r1,1 has no dependence.
    id_instr = ins(OP_LW, 4'd5, 4'd1, 4'd0);
    step();
    id_instr = ins(OP_ADDI, 4'd6, 4'd1, 4'd1);
    #1;
    check("nodep_stall", {15'd0, stall}, 16'd0);
    step();
    check("nodep_valid", {15'd0, ex_valid}, 16'd1);
    check("nodep_b", ex_b, 16'd1);
    $display("no-dep ADDI a=%h b=%h", ex_a, ex_b);

    // Load-use on rt: LW r5 then SW with rs=r1, rt=r5.
    id_instr = ins(OP_LW, 4'd5, 4'd1, 4'd0);
    step();
    id_instr = ins(OP_SW, 4'd0, 4'd1, 4'd5);
    #1;
    check("lu_rt_stall", {15'd0, stall}, 16'd1);
    step();
    check_bubble("lu_rt_bubble");
    check("lu_rt_release", {15'd0, stall}, 16'd0);
    step();
    check("sw_ctl", {12'd0, ex_valid, ex_we, ex_memread, ex_memwrite}, 16'b1001);
    check("sw_a", ex_a, 16'd5);
    check("sw_b", ex_b, 16'd5);
    check("sw_sd", ex_sd, 16'h00AA);
    $display("SW a=%h b=%h sd=%h", ex_a, ex_b, ex_sd);

    // LW r0 then ADD r6,r0,r0: r0 never hazards.
    id_instr = ins(OP_LW, 4'd0, 4'd1, 4'd0);
    step();
    id_instr = ins(OP_ADD, 4'd6, 4'd0, 4'd0);
    #1;
    check("lw_r0_stall", {15'd0, stall}, 16'd0);
    step();
    check("lw_r0_valid", {15'd0, ex_valid}, 16'd1);

    // Flush wins over a load-use stall.
    id_instr = ins(OP_LW, 4'd5, 4'd1, 4'd0);
    step();
    id_instr = ins(OP_ADD, 4'd6, 4'd5, 4'd2);
    flush = 1'b1;
    #1;
    check("flush_stall", {15'd0, stall}, 16'd0);
    step();
    flush = 1'b0;
    check_bubble("flush_bubble");
    $display("flush: valid=%b stall=%b", ex_valid, stall);

    // Same-cycle write-through bypass.
    wb_we = 1'b1; wb_rd = 4'd2; wb_data = 16'h1234;
    id_instr = ins(OP_ADD, 4'd3, 4'd2, 4'd0);
    step();
    wb_we = 1'b0;
    check("bypass_a", ex_a, 16'h1234);
    check("bypass_b", ex_b, 16'd0);
    $display("bypass a=%h b=%h", ex_a, ex_b);

    // Write to r0 is ignored.
    id_valid = 1'b0;
    wb_we = 1'b1; wb_rd = 4'd0; wb_data = 16'hFFFF;
    step();
    check("idle_bubble", {15'd0, ex_valid}, 16'd0);
    wb_we = 1'b0;
    id_valid = 1'b1;
    id_instr = ins(OP_ADD, 4'd3, 4'd0, 4'd2);
    step();
    check("r0_a", ex_a, 16'd0);
    check("r0_b", ex_b, 16'h1234);

    // Undefined opcode decodes as a bubble.
    id_instr = ins(4'hF, 4'd3, 4'd1, 4'd2);
    step();
    check_bubble("undef");

    // Reset asserted mid-stall.
    id_instr = ins(OP_LW, 4'd5, 4'd1, 4'd0);
    step();
    id_instr = ins(OP_ADD, 4'd6, 4'd5, 4'd2);
    #1;
    check("pre_rst_stall", {15'd0, stall}, 16'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_stall", {15'd0, stall}, 16'd0);
    step();
    rst = 1'b0;
    check_bubble("rst_mid_bubble");
    check("rst_mid_rd", {12'd0, ex_rd}, 16'd0);
    id_instr = ins(OP_ADD, 4'd3, 4'd1, 4'd2);
    #1;
    check("post_rst_stall", {15'd0, stall}, 16'd0);
    step();
    check("post_rst_valid", {15'd0, ex_valid}, 16'd1);
    check("post_rst_a", ex_a, 16'd0);
    $display("post-reset ADD a=%h b=%h", ex_a, ex_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
